// File: rtl/avl_ctrl_regfile_if.sv
// Avalon-MM slave bundle for the depth-core control register file.
// Master drives address/strobes/data; slave returns data and waitrequest.
interface avl_ctrl_regfile_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   avs_address;
  logic                avs_write;
  logic                avs_read;
  logic [DATA_W-1:0]   avs_writedata;
  logic [DATA_W/8-1:0] avs_byteenable;
  logic [DATA_W-1:0]   avs_readdata;
  logic                avs_readdatavalid;
  logic                avs_waitrequest;

  modport master (
    output avs_address, avs_write, avs_read,
    output avs_writedata, avs_byteenable,
    input  avs_readdata, avs_readdatavalid,
    input  avs_waitrequest
  );

  modport slave (
    input  avs_address, avs_write, avs_read,
    input  avs_writedata, avs_byteenable,
    output avs_readdata, avs_readdatavalid,
    output avs_waitrequest
  );
endinterface

// File: rtl/avl_ctrl_regfile.sv
// Control/status register file for the depth-estimation core.
// Define FAN_PWM_EN to enable the fan-duty PWM generator in CTRL[15:8].
module avl_ctrl_regfile #(
  parameter int ADDR_W   = 4,
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 8
) (
  input  logic clk,
  input  logic reset_n,
  avl_ctrl_regfile_if.slave avs,
  output logic start_o,
  output logic soft_rst_o,
  input  logic core_done_i,
  output logic [(NUM_REGS-3)*DATA_W-1:0] cfg_o,
  output logic irq_o,
  output logic fan_ctrl
);
  localparam int BE_W = DATA_W / 8;
  localparam int NCFG = NUM_REGS - 3;

  logic              wait_q;
  logic              acc;
  logic              wr;
  logic              rd;
  logic [ADDR_W:0]   addr;
  logic              sel_ctrl;
  logic              sel_stat;
  logic              go;
  logic              sft;
  logic              w1c;
  logic              irq_en_q;
  logic              busy_q;
  logic              done_q;
  logic [DATA_W-1:0] frame_q;
  logic [DATA_W-1:0] rdata;
  logic [DATA_W-1:0] wmask;
  logic [DATA_W-1:0] wdata;
  logic [BE_W-1:0]   be;
  logic [DATA_W-1:0] cfg_q [NCFG];
  logic [DATA_W-1:0] rdata_q;
  logic              rvalid_q;

  assign wdata    = avs.avs_writedata;
  assign be       = avs.avs_byteenable;
  assign addr     = {1'b0, avs.avs_address};
  assign acc      = ~wait_q;
  assign wr       = acc & avs.avs_write;
  assign rd       = acc & avs.avs_read & ~avs.avs_write;
  assign sel_ctrl = wr & (addr == (ADDR_W+1)'(0));
  assign sel_stat = wr & (addr == (ADDR_W+1)'(1));

  // soft reset takes precedence over a start bit in the same write
  assign sft = sel_ctrl & be[0] & wdata[1];
  assign go  = sel_ctrl & be[0] & wdata[0]
             & ~wdata[1] & ~busy_q;
  assign w1c = sel_stat & be[0] & wdata[1];

  always_comb begin
    wmask = '0;
    for (int b = 0; b < BE_W; b++)
      wmask[b*8 +: 8] = {8{be[b]}};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wait_q     <= 1'b1;
      start_o    <= 1'b0;
      soft_rst_o <= 1'b0;
      irq_o      <= 1'b0;
      irq_en_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      frame_q    <= '0;
    end else begin
      wait_q     <= 1'b0;
      start_o    <= go;
      soft_rst_o <= sft;
      irq_o      <= irq_en_q & done_q;
      if (sel_ctrl & be[0])
        irq_en_q <= wdata[2];
      if (sft)
        busy_q <= 1'b0;
      else if (go)
        busy_q <= 1'b1;
      else if (core_done_i)
        busy_q <= 1'b0;
      // a completion beats a same-cycle W1C
      if (sft)
        done_q <= 1'b0;
      else if (core_done_i)
        done_q <= 1'b1;
      else if (w1c)
        done_q <= 1'b0;
      if (sft)
        frame_q <= '0;
      else if (core_done_i)
        frame_q <= frame_q + DATA_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NCFG; i++)
        cfg_q[i] <= '0;
    end else begin
      for (int i = 0; i < NCFG; i++)
        if (wr && addr == (ADDR_W+1)'(i+3))
          cfg_q[i] <= (cfg_q[i] & ~wmask)
                    | (wdata & wmask);
    end
  end

  always_comb begin
    cfg_o = '0;
    for (int i = 0; i < NCFG; i++)
      cfg_o[i*DATA_W +: DATA_W] = cfg_q[i];
  end

`ifdef FAN_PWM_EN
  logic [7:0] duty_q;
  logic [7:0] cnt_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      duty_q <= 8'hFF;
      cnt_q  <= 8'd0;
    end else begin
      cnt_q <= cnt_q + 8'd1;
      if (sel_ctrl & be[1])
        duty_q <= wdata[15:8];
    end
  end

  assign fan_ctrl = (duty_q == 8'hFF)
                  | (cnt_q < duty_q);
`else
  assign fan_ctrl = 1'b1;
`endif

  always_comb begin
    rdata = '0;
    unique case (1'b1)
      addr == (ADDR_W+1)'(0): begin
        rdata[2] = irq_en_q;
`ifdef FAN_PWM_EN
        rdata[15:8] = duty_q;
`endif
      end
      addr == (ADDR_W+1)'(1): begin
        rdata[0] = busy_q;
        rdata[1] = done_q;
      end
      addr == (ADDR_W+1)'(2):
        rdata = frame_q;
      default: begin
        for (int i = 0; i < NCFG; i++)
          if (addr == (ADDR_W+1)'(i+3))
            rdata = cfg_q[i];
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      rvalid_q <= rd;
      rdata_q  <= rd ? rdata : '0;
    end
  end

  assign avs.avs_readdata      = rdata_q;
  assign avs.avs_readdatavalid = rvalid_q;
  assign avs.avs_waitrequest   = wait_q;
endmodule

// File: doc/avl_ctrl_regfile.md
AVL_CTRL_REGFILE -- requirements
Module: avl_ctrl_regfile

Interface
REQ-001 SHALL have parameter ADDR_W, default 4, Avalon-MM word-address width.
REQ-002 SHALL have parameter DATA_W, default 32, register/data width; legal range 16..64.
REQ-003 SHALL have parameter NUM_REGS, default 8, implemented registers; legal range 4..2^ADDR_W.
REQ-004 SHALL have one clock and an asynchronous, active-low reset.
REQ-005 clk  in  1  sole clock, all logic rising-edge.
REQ-006 reset_n  in  1  asynchronous active-low reset.
REQ-007 avs_address  in  ADDR_W  word address.
REQ-008 avs_write / avs_read  in  1 each  transfer strobes.
REQ-009 avs_writedata  in  DATA_W; avs_byteenable  in  DATA_W/8.
REQ-010 avs_readdata  out  DATA_W; avs_readdatavalid  out  1; avs_waitrequest  out  1.
REQ-011 start_o  out  1  one-cycle start pulse to depth-estimation core.
REQ-012 soft_rst_o  out  1  one-cycle soft-reset pulse to core.
REQ-013 core_done_i  in  1  one-cycle completion pulse from core.
REQ-014 cfg_o  out  (NUM_REGS-3)*DATA_W  flattened generic config registers, reg 3 in LSBs.
REQ-015 irq_o  out  1  level interrupt; fan_ctrl  out  1  fan drive.

Function
REQ-016 Map: 0 CTRL (RW), 1 STATUS (RO, bit1 W1C), 2 FRAME_CNT (RO), 3..NUM_REGS-1 CFG (RW).
REQ-017 CTRL bits: [0] start (write-1 pulses, reads 0), [1] soft reset (write-1 pulses, reads 0), [2] irq_en (RW), [15:8] fan duty (RW); other bits read 0.
REQ-018 STATUS bits: [0] busy, [1] done (sticky); other bits read 0.
REQ-019 Writes to RW registers SHALL honour avs_byteenable per byte.
REQ-020 Reads: fixed latency 1; avs_readdatavalid high exactly one cycle after avs_read accepted, avs_readdata valid that cycle, else 0.
REQ-021 avs_waitrequest SHALL be 1 during reset and in the first cycle after reset release, 0 otherwise.
REQ-022 avs_read and avs_write asserted together: write executes, read ignored (no readdatavalid).
REQ-023 Address >= NUM_REGS: write ignored, read returns 0 with readdatavalid.
REQ-024 Start write while busy=0: start_o pulses next cycle, busy set same edge.
REQ-025 Start write while busy=1: ignored, no pulse.
REQ-026 core_done_i: busy cleared, done set, FRAME_CNT +1 modulo 2^DATA_W (wraps all-ones -> 0).
REQ-027 core_done_i and start write same cycle with busy=1: done processed, start ignored.
REQ-028 core_done_i and W1C of done same cycle: done remains 1 (set wins).
REQ-029 core_done_i while busy=0: done set, FRAME_CNT incremented, busy unchanged.
REQ-030 Soft-reset write: soft_rst_o pulses next cycle; busy, done, FRAME_CNT cleared; CTRL and CFG retained; a start bit in same write ignored.
REQ-031 irq_o = irq_en AND done, registered (one cycle after either changes).

Reset
REQ-032 On reset_n low: avs_readdata=0, avs_readdatavalid=0, avs_waitrequest=1, start_o=0, soft_rst_o=0, irq_o=0, all registers 0 except fan duty = 8'hFF, fan_ctrl=1.
REQ-033 Reset mid-transfer SHALL abort it; no readdatavalid after reset release for a pre-reset read.

Configuration
REQ-034 Macro FAN_PWM_EN defined: fan_ctrl driven by 8-bit free-running counter (period 256 clk), high while counter < duty, except duty 8'hFF forces constant 1; counter resets to 0.
REQ-035 FAN_PWM_EN undefined: fan_ctrl constant 1, CTRL[15:8] unimplemented (reads 0, writes ignored).

Verification
REQ-036 Write CTRL=0x1 -> start_o one pulse, STATUS reads 0x1; second start before done -> no pulse.
REQ-037 Pulse core_done_i after start -> STATUS=0x2, FRAME_CNT=1; with irq_en=1 irq_o rises one cycle later; write STATUS=0x2 -> done=0, irq_o falls.
REQ-038 Write CFG reg 3 = 0xA5A5A5A5 with byteenable 4'b0011 after 0 -> reads 0x0000A5A5, cfg_o[31:0] matches.
REQ-039 Preload FRAME_CNT at all-ones via 2^32-1 done pulses (or force) -> next done gives 0.
REQ-040 Read address NUM_REGS+1 -> readdata 0, readdatavalid 1 cycle after read; simultaneous read+write -> no readdatavalid.
REQ-041 FAN_PWM_EN, duty 0x40 -> fan_ctrl high 64 of every 256 cycles; duty 0xFF -> always high; duty 0 -> always low.
